memory_access: RTL and testbench

- Pipeline stage directly downstream of execute.
- Consumes execute's registered outputs: ALU result as address, rs2 as store data, load/store info, write-back control.
- Performs loads and stores over a variable-latency data-memory request/grant/response interface, and stalls upstream while a transfer is outstanding.
- Aligns and extends load data and hands a single result to write-back.

---
 rtl/memory_access_pkg.sv | 27 ++
 rtl/memory_access_load_extend.sv | 41 ++++
 rtl/memory_access.sv | 224 ++++++++++++++++++++++
 tb/tb_memory_access.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared encodings and FSM state type for the memory-access pipeline stage.
package memory_access_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Encodings 6 and 7 are deliberately not loads.
    function automatic logic is_load_type(input logic [2:0] ld);
        return (ld >= LD_LB) && (ld <= LD_LHU);
    endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
    import memory_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_type,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension according to load type.
    always_comb begin
        byte_s  = 8'h00;
        half_s  = 16'h0000;
        ld_data = 32'h0000_0000;
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (ld_type)
            LD_LB:   ld_data = {{24{byte_s[7]}}, byte_s};
            LD_LBU:  ld_data = {24'h000000, byte_s};
            LD_LH:   ld_data = {{16{half_s[15]}}, half_s};
            LD_LHU:  ld_data = {16'h0000, half_s};
            LD_LW:   ld_data = rdata;
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access stage: issues loads/stores over a req/gnt/rvalid interface,
// stalls upstream while a transfer is outstanding and forwards one result to write-back.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           rs2E,
    input  logic                  write_regE,
    input  logic [2:0]            info_loadE,
    input  logic [1:0]            info_storeE,
    input  logic [4:0]            dstreg_addrE,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [31:0]           dmem_rdata,
    output logic                  wb_valid,
    output logic [31:0]           wb_data,
    output logic                  write_regM,
    output logic [4:0]            dstreg_addrM,
    output logic                  misalign
);

    state_e                state_r, state_nx_s;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [1:0]            addr_lo_r;
    logic [31:0]           wdata_r;
    logic [3:0]            be_r;
    logic [2:0]            ld_type_r;
    logic [4:0]            dst_r;
    logic                  wr_r;
    logic                  wb_valid_r, misalign_r, write_reg_m_r;
    logic [31:0]           wb_data_r;
    logic [4:0]            dst_m_r;

    logic        is_load_s, is_store_s, misal_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        accept_s, pass_s, mis_s, st_done_s, ld_done_s;
    logic [31:0] ld_data_s;

    // Decode the incoming op: precedence, misalignment and store lane placement.
    always_comb begin
        is_load_s  = is_load_type(info_loadE);
        is_store_s = !is_load_s && (info_storeE != ST_NONE);
        misal_s    = 1'b0;
        be_s       = 4'b1111;
        wdata_s    = 32'h0000_0000;
        if (is_load_s) begin
            case (info_loadE)
                LD_LH, LD_LHU: misal_s = alu_result[0];
                LD_LW:         misal_s = (alu_result[1:0] != 2'b00);
                default:       misal_s = 1'b0;
            endcase
        end else if (is_store_s) begin
            case (info_storeE)
                ST_SB: begin
                    be_s    = 4'b0001 << alu_result[1:0];
                    wdata_s = {4{rs2E[7:0]}};
                end
                ST_SH: begin
                    be_s    = alu_result[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{rs2E[15:0]}};
                    misal_s = alu_result[0];
                end
                ST_SW: begin
                    be_s    = 4'b1111;
                    wdata_s = rs2E;
                    misal_s = (alu_result[1:0] != 2'b00);
                end
                default: begin
                    be_s    = 4'b1111;
                    wdata_s = 32'h0000_0000;
                end
            endcase
        end else begin
            misal_s = 1'b0;
        end
    end

    // Next-state logic and single-cycle completion strobes.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        pass_s     = 1'b0;
        mis_s      = 1'b0;
        st_done_s  = 1'b0;
        ld_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid_in) begin
                    if (!(is_load_s || is_store_s)) begin
                        pass_s = 1'b1;
                    end else if (misal_s) begin
                        mis_s = 1'b1;
                    end else begin
                        accept_s   = 1'b1;
                        state_nx_s = REQ;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (we_r) begin
                        st_done_s  = 1'b1;
                        state_nx_s = IDLE;
                    end else if (dmem_rvalid) begin
                        ld_done_s  = 1'b1;
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = RESP;
                    end
                end else begin
                    state_nx_s = REQ;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    ld_done_s  = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    load_extend u_load_extend (
        .rdata   (dmem_rdata),
        .addr_lo (addr_lo_r),
        .ld_type (ld_type_r),
        .ld_data (ld_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Request latch and write-back result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r          <= 1'b0;
            addr_r        <= '0;
            addr_lo_r     <= 2'b00;
            wdata_r       <= 32'h0000_0000;
            be_r          <= 4'b0000;
            ld_type_r     <= LD_NONE;
            dst_r         <= 5'd0;
            wr_r          <= 1'b0;
            wb_valid_r    <= 1'b0;
            misalign_r    <= 1'b0;
            write_reg_m_r <= 1'b0;
            wb_data_r     <= 32'h0000_0000;
            dst_m_r       <= 5'd0;
        end else begin
            wb_valid_r <= 1'b0;
            misalign_r <= 1'b0;
            if (accept_s) begin
                we_r      <= is_store_s;
                addr_r    <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
                addr_lo_r <= alu_result[1:0];
                wdata_r   <= wdata_s;
                be_r      <= be_s;
                ld_type_r <= is_load_s ? info_loadE : LD_NONE;
                dst_r     <= dstreg_addrE;
                wr_r      <= write_regE;
            end
            if (pass_s) begin
                wb_valid_r    <= 1'b1;
                wb_data_r     <= alu_result;
                write_reg_m_r <= write_regE && (dstreg_addrE != 5'd0);
                dst_m_r       <= dstreg_addrE;
            end
            if (mis_s) begin
                wb_valid_r    <= 1'b1;
                misalign_r    <= 1'b1;
                write_reg_m_r <= 1'b0;
                dst_m_r       <= dstreg_addrE;
            end
            if (st_done_s) begin
                wb_valid_r    <= 1'b1;
                write_reg_m_r <= 1'b0;
                dst_m_r       <= dst_r;
            end
            if (ld_done_s) begin
                wb_valid_r    <= 1'b1;
                wb_data_r     <= ld_data_s;
                write_reg_m_r <= wr_r && (dst_r != 5'd0);
                dst_m_r       <= dst_r;
            end
        end
    end

    assign stall        = (state_r != IDLE);
    assign dmem_req     = (state_r == REQ);
    assign dmem_we      = we_r;
    assign dmem_addr    = addr_r;
    assign dmem_wdata   = wdata_r;
    assign dmem_be      = be_r;
    assign wb_valid     = wb_valid_r;
    assign wb_data      = wb_data_r;
    assign write_regM   = write_reg_m_r;
    assign dstreg_addrM = dst_m_r;
    assign misalign     = misalign_r;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access; inputs change and outputs are sampled on the falling edge.
module tb_memory_access;
    import memory_access_pkg::*;

    logic        clk, rst_n, valid_in, write_regE;
    logic [31:0] alu_result, rs2E, dmem_rdata, dmem_wdata, wb_data, dmem_addr;
    logic [2:0]  info_loadE;
    logic [1:0]  info_storeE;
    logic [4:0]  dstreg_addrE, dstreg_addrM;
    logic        stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [3:0]  dmem_be;
    logic        wb_valid, write_regM, misalign;

    int n_cmp = 0;
    int n_err = 0;

    memory_access #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result(alu_result),
        .rs2E(rs2E), .write_regE(write_regE), .info_loadE(info_loadE),
        .info_storeE(info_storeE), .dstreg_addrE(dstreg_addrE), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_data(wb_data), .write_regM(write_regM), .dstreg_addrM(dstreg_addrM),
        .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [4:0] dst, input logic wr);
        @(negedge clk);
        valid_in     = 1'b1;
        alu_result   = addr;
        rs2E         = rs2;
        info_loadE   = ld;
        info_storeE  = st;
        dstreg_addrE = dst;
        write_regE   = wr;
    endtask

    task automatic do_store(input string tag, input logic [1:0] st, input logic [31:0] addr,
                            input logic [31:0] rs2, input int gnt_delay, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        drive_op(LD_NONE, st, addr, rs2, 5'd7, 1'b1);
        for (int i = 0; i <= gnt_delay; i++) begin
            @(negedge clk);
            valid_in = 1'b0;
            check_eq({tag, ".req"},   {31'd0, dmem_req}, 32'd1);
            check_eq({tag, ".stall"}, {31'd0, stall}, 32'd1);
            check_eq({tag, ".we"},    {31'd0, dmem_we}, 32'd1);
            check_eq({tag, ".addr"},  dmem_addr, exp_addr);
            check_eq({tag, ".be"},    {28'd0, dmem_be}, {28'd0, exp_be});
            check_eq({tag, ".wdata"}, dmem_wdata, exp_wdata);
            dmem_gnt = (i == gnt_delay);
        end
        @(negedge clk);
        dmem_gnt = 1'b0;
        check_eq({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
        check_eq({tag, ".wr"},       {31'd0, write_regM}, 32'd0);
        check_eq({tag, ".stall_end"}, {31'd0, stall}, 32'd0);
        check_eq({tag, ".req_end"},  {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        check_eq({tag, ".pulse"},    {31'd0, wb_valid}, 32'd0);
    endtask

    // rv_delay 0: rvalid together with gnt; n: rvalid n cycles after the gnt cycle.
    task automatic do_load(input string tag, input logic [2:0] ld, input logic [31:0] addr,
                           input logic [31:0] rdata, input int gnt_delay, input int rv_delay,
                           input logic [4:0] dst, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data, input logic exp_wr);
        drive_op(ld, ST_NONE, addr, 32'hFFFF_FFFF, dst, 1'b1);
        for (int i = 0; i <= gnt_delay; i++) begin
            @(negedge clk);
            valid_in = 1'b0;
            check_eq({tag, ".req"},  {31'd0, dmem_req}, 32'd1);
            check_eq({tag, ".we"},   {31'd0, dmem_we}, 32'd0);
            check_eq({tag, ".be"},   {28'd0, dmem_be}, 32'h0000_000F);
            check_eq({tag, ".addr"}, dmem_addr, exp_addr);
            if (i == gnt_delay) begin
                dmem_gnt    = 1'b1;
                dmem_rvalid = (rv_delay == 0);
                dmem_rdata  = rdata;
            end else begin
                dmem_gnt    = 1'b0;
                dmem_rvalid = 1'b1;
                dmem_rdata  = 32'h5A5A_5A5A;
            end
        end
        if (rv_delay > 0) begin
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            check_eq({tag, ".resp_stall"}, {31'd0, stall}, 32'd1);
            check_eq({tag, ".resp_req"},   {31'd0, dmem_req}, 32'd0);
            for (int j = 2; j <= rv_delay; j++) @(negedge clk);
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
        end
        @(negedge clk);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0000_0000;
        check_eq({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
        check_eq({tag, ".wb_data"},  wb_data, exp_data);
        check_eq({tag, ".wr"},       {31'd0, write_regM}, {31'd0, exp_wr});
        check_eq({tag, ".dst"},      {27'd0, dstreg_addrM}, {27'd0, dst});
        check_eq({tag, ".stall_end"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        check_eq({tag, ".pulse"},    {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; alu_result = 32'h0; rs2E = 32'h0;
        write_regE = 1'b0; info_loadE = LD_NONE; info_storeE = ST_NONE;
        dstreg_addrE = 5'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk); @(negedge clk);
        check_eq("rst.stall",    {31'd0, stall}, 32'd0);
        check_eq("rst.req",      {31'd0, dmem_req}, 32'd0);
        check_eq("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst.wb_data",  wb_data, 32'd0);
        check_eq("rst.addr",     dmem_addr, 32'd0);
        check_eq("rst.be",       {28'd0, dmem_be}, 32'd0);
        rst_n = 1'b1;

        // Passthrough
        drive_op(LD_NONE, ST_NONE, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        check_eq("pass.stall0", {31'd0, stall}, 32'd0);
        @(negedge clk);
        valid_in = 1'b0;
        check_eq("pass.wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("pass.wb_data",  wb_data, 32'h0000_1234);
        check_eq("pass.wr",       {31'd0, write_regM}, 32'd1);
        check_eq("pass.dst",      {27'd0, dstreg_addrM}, 32'd5);
        check_eq("pass.stall1",   {31'd0, stall}, 32'd0);
        @(negedge clk);
        check_eq("pass.pulse",    {31'd0, wb_valid}, 32'd0);
        check_eq("pass.hold",     wb_data, 32'h0000_1234);

        do_store("sb", ST_SB, 32'h0000_0103, 32'hAABB_CCDD, 2, 32'h0000_0100, 4'b1000, 32'hDDDD_DDDD);
        do_store("sh", ST_SH, 32'h0000_0106, 32'h1234_5678, 0, 32'h0000_0104, 4'b1100, 32'h5678_5678);
        do_store("sw", ST_SW, 32'h0000_0208, 32'hCAFE_F00D, 1, 32'h0000_0208, 4'b1111, 32'hCAFE_F00D);

        do_load("lb",  LD_LB,  32'h0000_0202, 32'h0080_0000, 0, 2, 5'd3, 32'h0000_0200, 32'hFFFF_FF80, 1'b1);
        do_load("lbu", LD_LBU, 32'h0000_0202, 32'h0080_0000, 1, 2, 5'd4, 32'h0000_0200, 32'h0000_0080, 1'b1);
        do_load("lw",  LD_LW,  32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 5'd9, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1);
        do_load("lh0", LD_LH,  32'h0000_0402, 32'h8001_1234, 0, 1, 5'd0, 32'h0000_0400, 32'hFFFF_8001, 1'b0);
        do_load("lhu", LD_LHU, 32'h0000_0400, 32'hABCD_9876, 2, 3, 5'd6, 32'h0000_0400, 32'h0000_9876, 1'b1);
        do_load("lb3", LD_LB,  32'h0000_0013, 32'h7F00_00FF, 0, 1, 5'd8, 32'h0000_0010, 32'h0000_007F, 1'b1);

        // Misaligned LW
        drive_op(LD_LW, ST_NONE, 32'h0000_0041, 32'h0, 5'd2, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        check_eq("mis.misalign", {31'd0, misalign}, 32'd1);
        check_eq("mis.wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("mis.wr",       {31'd0, write_regM}, 32'd0);
        check_eq("mis.req",      {31'd0, dmem_req}, 32'd0);
        check_eq("mis.stall",    {31'd0, stall}, 32'd0);
        @(negedge clk);
        check_eq("mis.pulse",    {31'd0, misalign}, 32'd0);
        check_eq("mis.req2",     {31'd0, dmem_req}, 32'd0);

        // Reset while in REQ
        drive_op(LD_LW, ST_NONE, 32'h0000_0080, 32'h0, 5'd1, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        check_eq("rreq.req", {31'd0, dmem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rreq.req_drop",   {31'd0, dmem_req}, 32'd0);
        check_eq("rreq.stall_drop", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check_eq("rreq.stray_wb", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        check_eq("rreq.stray_wb2", {31'd0, wb_valid}, 32'd0);
        check_eq("rreq.stall_end", {31'd0, stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
